// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the 5-stage pipeline hazard/forwarding logic.
//   - fwd_sel_e : E-stage operand source select encoding
//   - REG_ADDR_W_DEF : default register-specifier width
package pipe_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,    // operand from register file / ID-EX register
        FWD_WB  = 2'b01,    // operand from the write-back result
        FWD_MEM = 2'b10     // operand from ALUOutM
    } fwd_sel_e;

endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker
// Occupancy tracker for the multi-cycle mult/div unit. A down-counter is
// loaded with MD_LATENCY when an operation is accepted and counts to zero.
// Ports:
//   clk    in  pipeline clock
//   rst    in  synchronous active-high reset (clears the counter)
//   accept in  a mult/div operation is accepted this cycle
//   busy   out unit occupied (counter nonzero)
module md_busy_tracker #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    output logic busy
);

    localparam int CNT_W = (MD_LATENCY < 1) ? 1 : $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] cntReg;
    logic [CNT_W-1:0] cntNext;

    // A new accept reloads even if the count has not quite reached zero,
    // which lets back-to-back operations start the cycle busy drops.
    always_comb begin
        cntNext = cntReg;
        if (accept) begin
            cntNext = CNT_W'(MD_LATENCY);
        end else if (cntReg != '0) begin
            cntNext = cntReg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntNext;
        end
    end

    assign busy = (cntReg != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for the F/D/E/M/W pipeline.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs_d, rt_d, uses_rs_d/rt_d    D-stage sources and their use qualifiers
//   branch_d, md_start_d, mfhilo_d D-stage instruction class flags
//   rs_e, rt_e, wreg_e, regwrite_e, memtoreg_e  E-stage fields
//   wreg_m, regwrite_m, memtoreg_m              M-stage fields
//   wreg_w, regwrite_w                          W-stage fields
//   stall_f, stall_d, flush_e     stall/bubble controls
//   fwd_a_d, fwd_b_d              D-stage branch comparator forwarding
//   fwd_a_e, fwd_b_e              E-stage operand selects (pipe_pkg encoding)
//   md_busy                       mult/div unit occupied
//   stall_cycles                  saturating stalled-cycle counter
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MD_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  uses_rs_d,
    input  logic                  uses_rt_d,
    input  logic                  branch_d,
    input  logic                  md_start_d,
    input  logic                  mfhilo_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] wreg_e,
    input  logic                  regwrite_e,
    input  logic                  memtoreg_e,
    input  logic [REG_ADDR_W-1:0] wreg_m,
    input  logic                  regwrite_m,
    input  logic                  memtoreg_m,
    input  logic [REG_ADDR_W-1:0] wreg_w,
    input  logic                  regwrite_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic                  fwd_a_d,
    output logic                  fwd_b_d,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic                  md_busy,
    output logic [PERF_W-1:0]     stall_cycles
);

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    // E-stage forwarding, identical for both operands.
    logic [REG_ADDR_W-1:0] srcE [2];
    logic [1:0]            fwdE [2];

    assign srcE[0] = rs_e;
    assign srcE[1] = rt_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd_e
            always_comb begin
                fwdE[gi] = FWD_RF;
                if (regwrite_m && regMatch(srcE[gi], wreg_m)) begin
                    fwdE[gi] = FWD_MEM;   // newest value wins
                end else if (regwrite_w && regMatch(srcE[gi], wreg_w)) begin
                    fwdE[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    // D-stage forwarding only from an ALU result in M; a load in M is not
    // ready yet and is covered by the branch stall instead.
    logic fwdAD;
    logic fwdBD;
    assign fwdAD = regwrite_m && !memtoreg_m && regMatch(rs_d, wreg_m);
    assign fwdBD = regwrite_m && !memtoreg_m && regMatch(rt_d, wreg_m);

    // Stall sources
    logic lwStall;
    logic brStall;
    logic mdStall;
    logic stallRaw;
    logic mdBusy;
    logic mdAccept;

    assign lwStall = memtoreg_e &&
                     ((uses_rs_d && regMatch(rs_d, wreg_e)) ||
                      (uses_rt_d && regMatch(rt_d, wreg_e)));

    assign brStall = branch_d &&
                     ((regwrite_e && (regMatch(rs_d, wreg_e) || regMatch(rt_d, wreg_e))) ||
                      (memtoreg_m && (regMatch(rs_d, wreg_m) || regMatch(rt_d, wreg_m))));

    assign mdStall  = (md_start_d || mfhilo_d) && mdBusy;
    assign stallRaw = lwStall || brStall || mdStall;

    // A mult/div that is itself stalled (by any hazard) must not start.
    assign mdAccept = md_start_d && !stallRaw && !rst;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .clk    (clk),
        .rst    (rst),
        .accept (mdAccept),
        .busy   (mdBusy)
    );

    // Saturating stalled-cycle counter
    logic [PERF_W-1:0] stallCyclesReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCyclesReg <= '0;
        end else if (stallRaw && (stallCyclesReg != '1)) begin
            stallCyclesReg <= stallCyclesReg + PERF_W'(1);
        end
    end

    // While in reset the pipeline is held clear: no stalls, D/E flushed,
    // and no forwarding from stale downstream state.
    always_comb begin
        if (rst) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_e = 1'b1;
            fwd_a_d = 1'b0;
            fwd_b_d = 1'b0;
            fwd_a_e = FWD_RF;
            fwd_b_e = FWD_RF;
        end else begin
            stall_f = stallRaw;
            stall_d = stallRaw;
            flush_e = stallRaw;
            fwd_a_d = fwdAD;
            fwd_b_d = fwdBD;
            fwd_a_e = fwdE[0];
            fwd_b_e = fwdE[1];
        end
    end

    assign md_busy      = mdBusy;
    assign stall_cycles = stallCyclesReg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expectations into a queue; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic       uses_rs_d, uses_rt_d, branch_d, md_start_d, mfhilo_d;
    logic       regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;

    logic        stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, md_busy;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [31:0] stall_cycles;

    logic        s4_f, s4_d, fl4, fad4, fbd4, busy4;
    logic [1:0]  fae4, fbe4;
    logic [3:0]  stall_cycles4;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .branch_d(branch_d),
        .md_start_d(md_start_d), .mfhilo_d(mfhilo_d),
        .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .wreg_m(wreg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .wreg_w(wreg_w), .regwrite_w(regwrite_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .branch_d(branch_d),
        .md_start_d(md_start_d), .mfhilo_d(mfhilo_d),
        .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .wreg_m(wreg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .wreg_w(wreg_w), .regwrite_w(regwrite_w),
        .stall_f(s4_f), .stall_d(s4_d), .flush_e(fl4),
        .fwd_a_d(fad4), .fwd_b_d(fbd4),
        .fwd_a_e(fae4), .fwd_b_e(fbe4),
        .md_busy(busy4), .stall_cycles(stall_cycles4)
    );

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        fwdAD;
        logic        fwdBD;
        logic [1:0]  fwdAE;
        logic [1:0]  fwdBE;
        logic        busy;
        logic [31:0] cycles;
        logic [3:0]  cycles4;
    } resp_t;

    resp_t expQ[$];
    string nameQ[$];
    int    nChecks = 0;
    int    nPass   = 0;
    int    stallCnt = 0;   // stalled cycles since last reset, bench-side

    // Monitor: the controller presents a response every cycle; compare
    // at the falling edge whenever an expectation is pending.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            resp_t e;
            resp_t a;
            string n;
            e = expQ.pop_front();
            n = nameQ.pop_front();
            a.stall   = stall_f;
            a.flush   = flush_e;
            a.fwdAD   = fwd_a_d;
            a.fwdBD   = fwd_b_d;
            a.fwdAE   = fwd_a_e;
            a.fwdBE   = fwd_b_e;
            a.busy    = md_busy;
            a.cycles  = stall_cycles;
            a.cycles4 = stall_cycles4;
            nChecks++;
            if (a === e && stall_d === stall_f) begin
                nPass++;
                $display("ok   %-12s stall=%0b flush=%0b fd=%0b%0b fe=%0d/%0d busy=%0b cyc=%0d cyc4=%0d",
                         n, a.stall, a.flush, a.fwdAD, a.fwdBD, a.fwdAE, a.fwdBE,
                         a.busy, a.cycles, a.cycles4);
            end else begin
                $display("FAIL %-12s got stall=%0b/%0b flush=%0b fd=%0b%0b fe=%0d/%0d busy=%0b cyc=%0d cyc4=%0d  want stall=%0b flush=%0b fd=%0b%0b fe=%0d/%0d busy=%0b cyc=%0d cyc4=%0d",
                         n, a.stall, stall_d, a.flush, a.fwdAD, a.fwdBD, a.fwdAE, a.fwdBE,
                         a.busy, a.cycles, a.cycles4,
                         e.stall, e.flush, e.fwdAD, e.fwdBD, e.fwdAE, e.fwdBE,
                         e.busy, e.cycles, e.cycles4);
            end
        end
    end

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        wreg_e = 0; wreg_m = 0; wreg_w = 0;
        uses_rs_d = 0; uses_rt_d = 0; branch_d = 0; md_start_d = 0; mfhilo_d = 0;
        regwrite_e = 0; memtoreg_e = 0; regwrite_m = 0; memtoreg_m = 0; regwrite_w = 0;
    endtask

    // Push the expectation for the inputs currently applied, then advance
    // one clock and update the bench's stalled-cycle tally.
    task automatic cyc(input string n, input logic st, input logic fad, input logic fbd,
                       input logic [1:0] fae, input logic [1:0] fbe, input logic busy);
        resp_t e;
        e.stall   = st;
        e.flush   = rst ? 1'b1 : st;
        e.fwdAD   = fad;
        e.fwdBD   = fbd;
        e.fwdAE   = fae;
        e.fwdBE   = fbe;
        e.busy    = busy;
        e.cycles  = 32'(stallCnt);
        e.cycles4 = (stallCnt > 15) ? 4'd15 : 4'(stallCnt);
        expQ.push_back(e);
        nameQ.push_back(n);
        @(posedge clk);
        if (rst) stallCnt = 0;
        else if (st) stallCnt++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;

        // reset: hazards present but outputs forced
        regwrite_m = 1; wreg_m = 8; rs_e = 8;
        memtoreg_e = 1; wreg_e = 9; rt_d = 9; uses_rt_d = 1;
        cyc("reset", 0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b0;

        // E forwarding priority
        idle(); regwrite_m = 1; wreg_m = 8; regwrite_w = 1; wreg_w = 8; rs_e = 8;
        cyc("fwdE_mem", 0, 0, 0, 2'b10, 2'b00, 0);
        idle(); regwrite_w = 1; wreg_w = 8; wreg_m = 8; rs_e = 8;
        cyc("fwdE_wb", 0, 0, 0, 2'b01, 2'b00, 0);
        idle(); regwrite_w = 1; wreg_w = 8; wreg_m = 8; rs_e = 0;
        cyc("fwdE_rf", 0, 0, 0, 2'b00, 2'b00, 0);
        idle(); regwrite_m = 1; wreg_m = 3; regwrite_w = 1; wreg_w = 3;
        rs_e = 3; rt_e = 3; rs_d = 3; rt_d = 3;
        cyc("fwd_both", 0, 1, 1, 2'b10, 2'b10, 0);
        idle(); regwrite_m = 1; regwrite_w = 1; wreg_m = 0; wreg_w = 0; rs_e = 0; rt_e = 0;
        cyc("fwd_r0", 0, 0, 0, 2'b00, 2'b00, 0);
        idle(); regwrite_m = 1; wreg_m = 7; rt_e = 7; regwrite_w = 1; wreg_w = 6; rs_e = 6;
        cyc("fwd_mix", 0, 0, 0, 2'b01, 2'b10, 0);
        idle(); regwrite_m = 1; memtoreg_m = 1; wreg_m = 5; rs_d = 5; rs_e = 5;
        cyc("fwdD_load", 0, 0, 0, 2'b10, 2'b00, 0);

        // load-use
        idle(); memtoreg_e = 1; wreg_e = 9; rt_d = 9; uses_rt_d = 1;
        cyc("lw_rt", 1, 0, 0, 2'b00, 2'b00, 0);
        idle(); memtoreg_e = 1; wreg_e = 9; rt_d = 9; uses_rt_d = 0;
        cyc("lw_unused", 0, 0, 0, 2'b00, 2'b00, 0);
        idle(); memtoreg_e = 1; wreg_e = 9; rs_d = 9; uses_rs_d = 1;
        cyc("lw_rs", 1, 0, 0, 2'b00, 2'b00, 0);
        idle(); memtoreg_e = 1; wreg_e = 0; rs_d = 0; uses_rs_d = 1;
        cyc("lw_r0", 0, 0, 0, 2'b00, 2'b00, 0);

        // branch hazards
        idle(); branch_d = 1; rs_d = 4; regwrite_e = 1; wreg_e = 4;
        cyc("br_e", 1, 0, 0, 2'b00, 2'b00, 0);
        idle(); branch_d = 1; rs_d = 4; regwrite_m = 1; memtoreg_m = 0; wreg_m = 4;
        cyc("br_m_fwd", 0, 1, 0, 2'b00, 2'b00, 0);
        idle(); branch_d = 1; rt_d = 6; regwrite_m = 1; memtoreg_m = 1; wreg_m = 6;
        cyc("br_m_load", 1, 0, 0, 2'b00, 2'b00, 0);

        // mult then mfhilo
        idle(); md_start_d = 1;
        cyc("md_accept", 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            idle(); mfhilo_d = 1;
            cyc("mfhi_wait", 1, 0, 0, 2'b00, 2'b00, 1);
        end
        idle(); mfhilo_d = 1;
        cyc("mfhi_go", 0, 0, 0, 2'b00, 2'b00, 0);

        // back-to-back mult
        idle(); md_start_d = 1;
        cyc("md_b2b_1", 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            idle(); md_start_d = 1;
            cyc("md_b2b_wait", 1, 0, 0, 2'b00, 2'b00, 1);
        end
        idle(); md_start_d = 1;
        cyc("md_b2b_2", 0, 0, 0, 2'b00, 2'b00, 0);
        idle(); mfhilo_d = 1;
        cyc("md_reload", 1, 0, 0, 2'b00, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            cyc("md_drain", 0, 0, 0, 2'b00, 2'b00, 1);
        end
        idle();
        cyc("md_idle", 0, 0, 0, 2'b00, 2'b00, 0);

        // lw stall blocks a mult start
        idle(); memtoreg_e = 1; wreg_e = 9; rs_d = 9; uses_rs_d = 1; md_start_d = 1;
        cyc("lw_md", 1, 0, 0, 2'b00, 2'b00, 0);
        idle();
        cyc("lw_md_none", 0, 0, 0, 2'b00, 2'b00, 0);

        // reset mid-operation
        idle(); md_start_d = 1;
        cyc("rst_accept", 0, 0, 0, 2'b00, 2'b00, 0);
        idle(); mfhilo_d = 1;
        cyc("rst_wait", 1, 0, 0, 2'b00, 2'b00, 1);
        rst = 1'b1;
        cyc("rst_pulse", 0, 0, 0, 2'b00, 2'b00, 1);
        rst = 1'b0;
        cyc("rst_mfhi_go", 0, 0, 0, 2'b00, 2'b00, 0);

        // continuous stall: 4-bit counter saturates at 15
        for (int i = 0; i < 17; i++) begin
            idle(); memtoreg_e = 1; wreg_e = 2; rt_d = 2; uses_rt_d = 1;
            cyc("sat_stall", 1, 0, 0, 2'b00, 2'b00, 0);
        end
        idle();
        cyc("sat_hold", 0, 0, 0, 2'b00, 2'b00, 0);

        @(negedge clk); #1;
        nChecks++;
        if (expQ.size() == 0) nPass++;
        else $display("FAIL drain pending=%0d want 0", expQ.size());

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W) and the successor to the fixed-width hazard unit. It adds three things the current unit does not have: operand-use qualifiers, a multi-cycle multiply/divide (HI/LO) occupancy tracker, and a saturating stall-cycle performance counter. It sits beside the pipeline registers. It drives the F/D stall enables, the D/E flush, and the D- and E-stage forwarding mux selects.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MD_LATENCY, 4, cycles the mult/div unit stays busy after accepting an operation; must be ≥1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- rs_d, rt_d  in  REG_ADDR_W  D-stage source specifiers.
- uses_rs_d, uses_rt_d  in  1  D-stage instruction actually reads rs/rt.
- branch_d  in  1  D-stage instruction is a branch resolved in D.
- md_start_d  in  1  D-stage instruction is mult/div.
- mfhilo_d  in  1  D-stage instruction reads HI/LO.
- rs_e, rt_e, wreg_e  in  REG_ADDR_W  E-stage specifiers and destination.
- regwrite_e, memtoreg_e  in  1  E-stage write-back controls.
- wreg_m  in  REG_ADDR_W; regwrite_m, memtoreg_m  in  1  M-stage controls.
- wreg_w  in  REG_ADDR_W; regwrite_w  in  1  W-stage controls.
- stall_f, stall_d  out  1  hold PC and the F/D register.
- flush_e  out  1  clear the D/E register (insert bubble).
- fwd_a_d, fwd_b_d  out  1  select ALUOutM for the D-stage branch comparator.
- fwd_a_e, fwd_b_e  out  2  E-stage operand select.
- md_busy  out  1  mult/div occupied.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

## Operation
- Register 0 never matches. Every comparison also requires the specifier to be nonzero.
- E forwarding (A uses rs_e, B uses rt_e):
  - MEM (2'b10) if regwrite_m and wreg_m matches.
  - Else WB (2'b01) if regwrite_w and wreg_w matches.
  - Else RF (2'b00). MEM has priority over WB.
- D forwarding: fwd_a_d = regwrite_m & !memtoreg_m & wreg_m==rs_d. fwd_b_d is the same using rt_d.
- lw_stall: memtoreg_e and wreg_e matches (uses_rs_d & rs_d) or (uses_rt_d & rt_d).
- br_stall: branch_d and either of:
  - regwrite_e and wreg_e ∈ {rs_d, rt_d};
  - memtoreg_m and wreg_m ∈ {rs_d, rt_d}.
- md_stall: (md_start_d | mfhilo_d) & md_busy.
- stall = lw_stall | br_stall | md_stall. Outputs: stall_f = stall_d = flush_e = stall.
- The md tracker counter (width $clog2(MD_LATENCY+1)) changes as follows:
  - If md_start_d & !stall: load MD_LATENCY.
  - Else if nonzero: decrement.
  - md_busy = (counter != 0).
- stall_cycles increments on every clock with stall=1 and holds at all-ones.
- Reset:
  - md counter, md_busy and stall_cycles go to 0.
  - While rst=1, outputs are forced to stall_f=stall_d=0, flush_e=1, and all forward selects 0.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and counter state. There is no added latency.
- md_start_d accepted at cycle T:
  - md_busy=1 in cycles T+1 through T+MD_LATENCY, and 0 at T+MD_LATENCY+1.
  - mfhilo_d present at T+1 stalls through T+MD_LATENCY and proceeds at T+MD_LATENCY+1.
- Back-to-back mult (md_start_d while busy): stalls, and is accepted in the first cycle md_busy=0, reloading the counter that same cycle.
- Simultaneous lw_stall and md_start_d with md idle: the mult is not accepted and the counter stays 0.
- rst asserted mid-operation: the counter clears at the next edge. A pending mfhilo proceeds once rst deasserts.
- stall_cycles at all-ones with stall=1: holds, no wrap.

## Structure
- Shared package pipe_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the REG_ADDR_W default.
- One sub-module, md_busy_tracker: parameter MD_LATENCY; ports clk, rst, accept, busy. It contains the down-counter.
- The forwarding and stall logic stays flat in pipe_hazard_ctrl.

## Test plan
- regwrite_m=1, wreg_m=8 and regwrite_w=1, wreg_w=8, with rs_e=8 → fwd_a_e=2'b10. Drop regwrite_m → 2'b01. Set rs_e=0 → 2'b00.
- memtoreg_e=1, wreg_e=9, rt_d=9: with uses_rt_d=1 → stall_f=stall_d=flush_e=1. With uses_rt_d=0 → no stall.
- branch_d=1, rs_d=4, regwrite_e=1, wreg_e=4 → stall. Move the writer to M with memtoreg_m=0 → no stall and fwd_a_d=1.
- MD_LATENCY=4, mult accepted at cycle 10, mfhilo_d held from 11 → stall in cycles 11–14, released at 15; stall_cycles advances by 4.
- Pulse rst at cycle 12 of the above → md_busy=0 at 13, mfhilo proceeds after deassert, and stall_cycles=0.
- PERF_W=4 with continuous stall → stall_cycles reaches 15 and holds at 15.
